// File: rtl/instruction_fetch_pkg.sv
// Shared processor definitions: fetch FSM encoding, default widths, reset PC.
package instruction_fetch_pkg;
    localparam int IF_WIDTH = 16;
    localparam int IF_ADDR_BITS = 16;
    localparam logic [15:0] IF_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_DELIVER  = 2'd2,
        S_PREFETCH = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_pc_counter.sv
// Program counter: load has priority over increment, wraps modulo 2^WIDTH.
module pc_counter
    import instruction_fetch_pkg::*;
#(
    parameter int WIDTH = IF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_pc
);
    logic [WIDTH-1:0] r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= WIDTH'(IF_RESET_PC);
        end else if (i_load) begin
            r_pc <= i_load_value;
        end else if (i_inc) begin
            r_pc <= r_pc + WIDTH'(1);
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch engine: PC, memory req/ack handshake, instr_en strobe.
// Optional one-entry prefetch buffer enabled by FETCH_PREFETCH_EN.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int WIDTH = IF_WIDTH,
    parameter int ADDR_BITS = IF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic                 pc_load,
    input  logic [WIDTH-1:0]     pc_load_value,
    output logic                 mem_rd,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic [WIDTH-1:0]     instr_out,
    output logic                 instr_en,
    output logic [WIDTH-1:0]     pc,
    output logic                 busy
);
    fetch_state_e         r_state, w_state_nxt;
    logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic [WIDTH-1:0]     r_instr, w_instr_nxt;
    logic                 r_abort, w_abort_nxt;
    logic                 w_pc_inc;
    logic [WIDTH-1:0]     w_pc;
    logic [WIDTH-1:0]     w_tgt_pc;

`ifdef FETCH_PREFETCH_EN
    logic                 r_pf_valid, w_pf_valid_nxt;
    logic [WIDTH-1:0]     r_pf_data, w_pf_data_nxt;
    logic [ADDR_BITS-1:0] r_pf_addr, w_pf_addr_nxt;
    logic                 r_pend, w_pend_nxt;
    logic                 w_pf_hit;
    logic                 w_pend;

    assign w_pf_hit = r_pf_valid && !pc_load && (r_pf_addr == ADDR_BITS'(w_pc));
    assign w_pend   = r_pend || fetch_req;
`endif

    // A same-cycle jump retargets the fetch address immediately
    assign w_tgt_pc = pc_load ? pc_load_value : w_pc;

    pc_counter #(.WIDTH(WIDTH)) u_pc (
        .clk          (clk),
        .reset        (reset),
        .i_load       (pc_load),
        .i_load_value (pc_load_value),
        .i_inc        (w_pc_inc),
        .o_pc         (w_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_instr <= '0;
            r_abort <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            r_pf_valid <= 1'b0;
            r_pf_data  <= '0;
            r_pf_addr  <= '0;
            r_pend     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_instr <= w_instr_nxt;
            r_abort <= w_abort_nxt;
`ifdef FETCH_PREFETCH_EN
            r_pf_valid <= w_pf_valid_nxt;
            r_pf_data  <= w_pf_data_nxt;
            r_pf_addr  <= w_pf_addr_nxt;
            r_pend     <= w_pend_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_instr_nxt = r_instr;
        w_abort_nxt = r_abort;
        w_pc_inc    = 1'b0;
`ifdef FETCH_PREFETCH_EN
        w_pf_valid_nxt = r_pf_valid && !pc_load;
        w_pf_data_nxt  = r_pf_data;
        w_pf_addr_nxt  = r_pf_addr;
        w_pend_nxt     = r_pend;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_abort_nxt = 1'b0;
                if (fetch_req) begin
`ifdef FETCH_PREFETCH_EN
                    if (w_pf_hit) begin
                        w_instr_nxt    = r_pf_data;
                        w_pc_inc       = 1'b1;
                        w_pf_valid_nxt = 1'b0;
                        w_state_nxt    = S_DELIVER;
                    end else begin
                        w_addr_nxt  = ADDR_BITS'(w_tgt_pc);
                        w_state_nxt = S_REQ;
                    end
`else
                    w_addr_nxt  = ADDR_BITS'(w_tgt_pc);
                    w_state_nxt = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (pc_load) begin
                    w_abort_nxt = 1'b1;
                end
                if (mem_ack) begin
                    if (r_abort || pc_load) begin
                        // Drop the stale word and re-request at the jump target
                        w_addr_nxt  = ADDR_BITS'(w_tgt_pc);
                        w_abort_nxt = 1'b0;
                    end else begin
                        w_instr_nxt = mem_rdata;
                        w_pc_inc    = 1'b1;
                        w_state_nxt = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
`ifdef FETCH_PREFETCH_EN
                w_addr_nxt  = ADDR_BITS'(w_tgt_pc);
                w_pend_nxt  = 1'b0;
                w_state_nxt = S_PREFETCH;
`else
                w_state_nxt = S_IDLE;
`endif
            end
`ifdef FETCH_PREFETCH_EN
            S_PREFETCH: begin
                if (pc_load) begin
                    w_abort_nxt = 1'b1;
                end
                if (fetch_req) begin
                    w_pend_nxt = 1'b1;
                end
                if (mem_ack) begin
                    w_abort_nxt = 1'b0;
                    w_pend_nxt  = 1'b0;
                    if (r_abort || pc_load) begin
                        if (w_pend) begin
                            w_addr_nxt  = ADDR_BITS'(w_tgt_pc);
                            w_state_nxt = S_REQ;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else if (w_pend) begin
                        w_instr_nxt = mem_rdata;
                        w_pc_inc    = 1'b1;
                        w_state_nxt = S_DELIVER;
                    end else begin
                        w_pf_data_nxt  = mem_rdata;
                        w_pf_addr_nxt  = r_addr;
                        w_pf_valid_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef FETCH_PREFETCH_EN
    assign mem_rd = (r_state == S_REQ) || (r_state == S_PREFETCH);
    assign busy   = (r_state == S_REQ) || (r_state == S_DELIVER)
                 || ((r_state == S_PREFETCH) && r_pend);
`else
    assign mem_rd = (r_state == S_REQ);
    assign busy   = (r_state == S_REQ) || (r_state == S_DELIVER);
`endif

    assign mem_addr  = r_addr;
    assign instr_out = r_instr;
    assign instr_en  = (r_state == S_DELIVER);
    assign pc        = w_pc;
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch engine that sources the 16-bit instruction word and its load strobe for the instruction register. It runs the program counter (PC), reads memory over a request/acknowledge handshake and presents the fetched word on instr_out with a one-cycle instr_en pulse.
- Sits between the top-level controller FSM (fetch_req, pc_load) and the unified instruction/data memory port.

Parameters:
- WIDTH, 16, instruction word and PC width.
- ADDR_BITS, 16, memory address width; PC is truncated/zero-extended to this width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- fetch_req  input  1  single-cycle pulse from controller requesting the next instruction
- pc_load  input  1  load PC from pc_load_value (jump/branch target)
- pc_load_value  input  WIDTH  new PC value
- mem_rd  output  1  memory read request, held until mem_ack
- mem_addr  output  ADDR_BITS  read address, stable while mem_rd is high
- mem_ack  input  1  memory acknowledge; mem_rdata valid in the same cycle
- mem_rdata  input  WIDTH  memory read data
- instr_out  output  WIDTH  last fetched instruction word, held between fetches
- instr_en  output  1  one-cycle strobe; connects to the instruction register enable
- pc  output  WIDTH  current PC (address of next instruction to fetch)
- busy  output  1  high whenever a fetch is in flight

Behaviour:
- Reset (async, active-high): pc=0, instr_out=0, instr_en=0, mem_rd=0, mem_addr=0, busy=0, FSM=IDLE, abort flag=0. Outputs take these values immediately, not at the next edge.
- FSM states are IDLE, REQ and DELIVER.
- IDLE, fetch_req=1: mem_addr<=pc, mem_rd<=1, busy<=1, go to REQ.
- REQ: hold mem_rd and mem_addr. On mem_ack, capture mem_rdata into instr_out, drop mem_rd, pc<=pc+1, go to DELIVER.
- DELIVER: instr_en=1 for exactly this cycle, busy=0 next cycle, return to IDLE.
- Minimum latency is fetch_req at cycle N, mem_ack at N+1, instr_en at N+2.
- Zero-wait memory is legal: mem_ack is allowed in the first REQ cycle. Unbounded wait is also legal; there is no timeout.
- The PC increments modulo 2^WIDTH, so 0xFFFF+1 = 0x0000.
- pc_load in IDLE: pc<=pc_load_value next cycle.
- pc_load and fetch_req in the same IDLE cycle: the fetch uses pc_load_value as its address. pc then becomes pc_load_value+1 after the ack.
- pc_load while in REQ:
  - pc<=pc_load_value and the abort flag is set.
  - The memory handshake still completes. On mem_ack the data is discarded: instr_out is unchanged, no instr_en pulse and no PC increment.
  - The FSM then reissues the request automatically at the new pc, remaining busy.
- pc_load in DELIVER: the delivered instruction is still strobed. pc<=pc_load_value overrides the increment.
- fetch_req while busy=1 (REQ or DELIVER) is ignored. The controller must wait for busy=0.
- instr_out changes only on a captured ack and is stable at least until the next instr_en.
- Reset mid-fetch: mem_rd drops asynchronously. A late mem_ack after reset is ignored (FSM is in IDLE).

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- Defined: adds a one-entry prefetch buffer (data plus valid bit) and a PREFETCH state.
  - After DELIVER, the FSM issues a read of pc without a request and stores the result with valid=1.
  - A fetch_req with valid=1 at a matching address skips REQ: instr_en asserts the next cycle, pc increments and valid clears.
  - pc_load invalidates the buffer. If a prefetch is in flight, its ack is discarded.
  - If fetch_req arrives during an in-flight prefetch, it is served on that ack.
- Undefined: no buffer and no PREFETCH state. mem_rd is asserted only in response to fetch_req or an abort reissue.

Decomposition:
- Shared package (the existing processor definitions package):
  - FSM state encoding constants for IDLE/REQ/DELIVER/PREFETCH.
  - WIDTH/ADDR_BITS defaults.
  - Reset PC constant (0).
- Sub-module pc_counter: holds PC and handles load, increment and wrap, with async reset.
- The FSM and capture logic stay in instruction_fetch.
- Registers use the codebase's enable/reset flop style.

Test Plan:
- Reset, fetch_req, memory acks next cycle with 0x5A3C -> instr_en pulses once at N+2, instr_out=0x5A3C, pc=0x0001, busy low after.
- Memory stalls 5 cycles with mem_rdata=0x1234 -> mem_rd and mem_addr=0x0001 held all 5 cycles, single instr_en, pc=0x0002.
- pc_load 0x0040 during REQ at pc=0x0010, ack returns 0xDEAD -> no instr_en and instr_out unchanged. Reissue at 0x0040, ack 0xBEEF -> instr_en, instr_out=0xBEEF, pc=0x0041.
- pc_load 0xFFFF then fetch -> mem_addr=0xFFFF, pc wraps to 0x0000.
- fetch_req pulsed while busy -> ignored: exactly one instr_en and one memory read. Assert reset during REQ -> mem_rd=0 immediately, pc=0; a late ack produces no instr_en.
- FETCH_PREFETCH_EN: two back-to-back fetches at 0x0000 and 0x0001 -> the second instr_en comes one cycle after fetch_req. pc_load 0x0100 invalidates the buffer, and the next fetch goes to memory at 0x0100.
